dffrsnq_bank_init_seq: RTL and testbench
========================================

# dffrsnq_bank_init_seq

Sequencer that loads an initial value into a bank of async set/clear flops (dffrsnq family) through their SETN/RN pins. It sits directly upstream of the bank and drives one SETN/RN pair per bit. It clears the 0-bits and then sets the 1-bits as two separate, registered, non-overlapping low pulses. SETN and RN are never low together on any bit, and there are no combinational glitches on the async pins.

## Interface
Parameters:
- WIDTH, 8: number of flops in the driven bank.
- PULSE_CYC, 2: length of each clear/set low pulse, in CLK cycles; must be ≥1.
- GAP_CYC, 1: all-high guard interval after each pulse, in cycles; must be ≥1.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RN  in  1  reset, synchronous, active-low.
- REQ  in  1  start request; sampled only while idle.
- INIT  in  WIDTH  value to load; captured on the cycle REQ is accepted.
- BUSY  out  1  high from acceptance until ACK is deasserted.
- ACK  out  1  one-cycle completion pulse.
- RN_O  out  WIDTH  per-bit clear to the bank, active-low.
- SETN_O  out  WIDTH  per-bit set to the bank, active-low.

## Operation
- Reset (RN=0 at an edge):
  - State goes to IDLE.
  - RN_O and SETN_O go all-ones.
  - BUSY=0, ACK=0, counter=0, captured INIT discarded.
  - Reset has priority over REQ.
- Reset mid-sequence: any pulse in flight is released on the next edge (outputs all-ones). No ACK is issued.
- States: IDLE → CLR → GAP1 → SET → GAP2 → DONE → IDLE.
  - IDLE: outputs all-ones. If REQ=1: capture INIT into init_q, load counter=PULSE_CYC-1, go to CLR.
  - CLR: RN_O = init_q (only 0-bits are driven low); SETN_O all-ones. When the counter reaches 0, load GAP_CYC-1 and go to GAP1; otherwise decrement.
  - GAP1: both outputs all-ones. At counter 0, load PULSE_CYC-1 and go to SET.
  - SET: SETN_O = ~init_q (only 1-bits are driven low); RN_O all-ones. At counter 0, load GAP_CYC-1 and go to GAP2.
  - GAP2: both outputs all-ones. At counter 0, go to DONE.
  - DONE: ACK=1 for exactly one cycle, then IDLE.
- All outputs come directly from flops, with no logic between a flop and the port.
- Sequence length is fixed and independent of data.
  - INIT all-zeros: SET phase still runs with no bit low.
  - INIT all-ones: CLR phase still runs with no bit low.
- Invariant: for every bit i, RN_O[i]=0 and SETN_O[i]=0 never occur in the same cycle. In addition, RN_O is all-ones whenever any SETN_O bit is low, and vice versa.
- REQ is ignored in every state other than IDLE, including DONE. REQ is not queued.
- INIT changes after acceptance have no effect.
- Counter width is $clog2(max(PULSE_CYC, GAP_CYC)+1).
- Elaboration fails if PULSE_CYC<1 or GAP_CYC<1.

## Timing
Let edge 0 be the edge that accepts REQ, P = PULSE_CYC and G = GAP_CYC.
- RN_O is low (0-bits) from edge 0 through edge P-1 and back high at edge P.
- All-high guard from edge P through edge P+G-1.
- SETN_O is low (1-bits) from edge P+G through edge 2P+G-1 and back high at edge 2P+G.
- All-high guard from edge 2P+G through edge 2P+2G-1.
- ACK=1 from edge 2P+2G to edge 2P+2G+1.
- BUSY=1 from edge 0 through edge 2P+2G+1, when it falls together with ACK.
- The earliest next acceptance is at edge 2P+2G+2.
- Defaults (P=2, G=1): clear pulse 2 cycles, set pulse 2 cycles, ACK after edge 6, next REQ accepted at edge 8.

## Test plan
- WIDTH=8, defaults, INIT=0xA5, REQ at edge 0:
  - RN_O=0xA5 after edges 0–1, then 0xFF at edge 2.
  - SETN_O=0x5A after edges 3–4, then 0xFF at edge 5.
  - ACK=1 only after edge 6; BUSY falls at edge 7.
- INIT=0x00, then INIT=0xFF:
  - Both sequences take identical latency (ACK after edge 6).
  - 0x00: SETN_O stays 0xFF throughout.
  - 0xFF: RN_O stays 0xFF throughout.
- REQ held high continuously with INIT toggling every cycle: accepted only at edges 0, 8, 16, …. Each load uses the INIT value present on its acceptance edge.
- RN pulsed low while in SET (after edge 3):
  - Outputs are 0xFF, BUSY=0 and ACK=0 after that edge, and ACK never appears.
  - REQ asserted together with RN=0 is not accepted.
- Per-bit overlap checker running across random INIT/REQ/RN stimulus for 10k cycles:
  - zero violations of the per-bit SETN_O/RN_O invariant;
  - zero cycles where RN_O≠all-ones while SETN_O≠all-ones.
- Parameter sweep P=1, G=1 and P=4, G=3: ACK lands after edge 2P+2G (4 and 14 respectively).

Source files
------------

// File: rtl/dffrsnq_bank_init_seq.sv
// rtl/dffrsnq_bank_init_seq.sv - loads a value into an async set/clear flop bank via non-overlapping clear/set pulses
module dffrsnq_bank_init_seq #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             REQ,
    input  logic [WIDTH-1:0] INIT,
    output logic             BUSY,
    output logic             ACK,
    output logic [WIDTH-1:0] RN_O,
    output logic [WIDTH-1:0] SETN_O
);

    localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] G_LD = CW'(GAP_CYC - 1);

    generate
        if (PULSE_CYC < 1 || GAP_CYC < 1) begin : g_bad_params
            $error("PULSE_CYC and GAP_CYC must both be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_GAP1,
        S_SET,
        S_GAP2,
        S_DONE
    } state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [WIDTH-1:0]  init_q, init_nx;
    logic [WIDTH-1:0]  rn_nx, setn_nx;
    logic              busy_nx, ack_nx;
    logic              last;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        init_nx  = init_q;
        last     = (cnt == '0);
        case (state)
            S_IDLE: begin
                if (REQ) begin
                    state_nx = S_CLR;
                    cnt_nx   = P_LD;
                    init_nx  = INIT;
                end
            end
            S_CLR: begin
                if (last) begin
                    state_nx = S_GAP1;
                    cnt_nx   = G_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_GAP1: begin
                if (last) begin
                    state_nx = S_SET;
                    cnt_nx   = P_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_SET: begin
                if (last) begin
                    state_nx = S_GAP2;
                    cnt_nx   = G_LD;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_GAP2: begin
                if (last) begin
                    state_nx = S_DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase

        // Outputs are decoded from the next state so each port is a bare flop.
        rn_nx   = (state_nx == S_CLR) ? init_nx : '1;
        setn_nx = (state_nx == S_SET) ? ~init_nx : '1;
        busy_nx = (state_nx != S_IDLE);
        ack_nx  = (state_nx == S_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state  <= S_IDLE;
            cnt    <= '0;
            init_q <= '0;
            RN_O   <= '1;
            SETN_O <= '1;
            BUSY   <= 1'b0;
            ACK    <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            init_q <= init_nx;
            RN_O   <= rn_nx;
            SETN_O <= setn_nx;
            BUSY   <= busy_nx;
            ACK    <= ack_nx;
        end
    end

endmodule

// File: tb/tb_dffrsnq_bank_init_seq.sv
// tb/tb_dffrsnq_bank_init_seq.sv - scoreboard bench for three parameterisations sharing one stimulus
module tb_dffrsnq_bank_init_seq;

    logic       CLK;
    logic       RN;
    logic       REQ;
    logic [7:0] INIT;

    logic       busy0, ack0, busy1, ack1, busy2, ack2;
    logic [7:0] rn_o0, setn_o0, rn_o1, setn_o1, rn_o2, setn_o2;

    dffrsnq_bank_init_seq #(.WIDTH(8), .PULSE_CYC(2), .GAP_CYC(1)) dut (
        .CLK(CLK), .RN(RN), .REQ(REQ), .INIT(INIT),
        .BUSY(busy0), .ACK(ack0), .RN_O(rn_o0), .SETN_O(setn_o0)
    );
    dffrsnq_bank_init_seq #(.WIDTH(8), .PULSE_CYC(1), .GAP_CYC(1)) dut_p1g1 (
        .CLK(CLK), .RN(RN), .REQ(REQ), .INIT(INIT),
        .BUSY(busy1), .ACK(ack1), .RN_O(rn_o1), .SETN_O(setn_o1)
    );
    dffrsnq_bank_init_seq #(.WIDTH(8), .PULSE_CYC(4), .GAP_CYC(3)) dut_p4g3 (
        .CLK(CLK), .RN(RN), .REQ(REQ), .INIT(INIT),
        .BUSY(busy2), .ACK(ack2), .RN_O(rn_o2), .SETN_O(setn_o2)
    );

    typedef struct packed {
        logic [7:0] rn;
        logic [7:0] setn;
        logic       busy;
        logic       ack;
    } obs_t;

    typedef struct packed {
        obs_t d2;
        obs_t d1;
        obs_t d0;
    } exp_t;

    exp_t sb [$];
    int   compared   = 0;
    int   mismatched = 0;

    // Timeline model: t = edges since acceptance, -1 when idle.
    int         pc [3] = '{2, 1, 4};
    int         gc [3] = '{1, 1, 3};
    int         t  [3];
    logic [7:0] iq [3];

    always #5 CLK = ~CLK;

    function automatic obs_t model_out(input int k);
        obs_t o;
        int   p = pc[k];
        int   g = gc[k];
        o.rn   = 8'hFF;
        o.setn = 8'hFF;
        o.busy = 1'b0;
        o.ack  = 1'b0;
        if (t[k] >= 0) begin
            o.busy = 1'b1;
            if (t[k] < p) o.rn = iq[k];
            if (t[k] >= p + g && t[k] < 2 * p + g) o.setn = ~iq[k];
            o.ack = (t[k] == 2 * p + 2 * g);
        end
        return o;
    endfunction

    task automatic model_edge(input logic req, input logic rn_in, input logic [7:0] init_v);
        for (int k = 0; k < 3; k++) begin
            if (!rn_in) begin
                t[k] = -1;
            end else if (t[k] < 0) begin
                if (req) begin
                    t[k]  = 0;
                    iq[k] = init_v;
                end
            end else begin
                t[k] = t[k] + 1;
                if (t[k] > 2 * pc[k] + 2 * gc[k]) t[k] = -1;
            end
        end
    endtask

    task automatic step(input logic req, input logic rn_in, input logic [7:0] init_v);
        exp_t e;
        @(negedge CLK);
        REQ  = req;
        RN   = rn_in;
        INIT = init_v;
        model_edge(req, rn_in, init_v);
        e.d0 = model_out(0);
        e.d1 = model_out(1);
        e.d2 = model_out(2);
        sb.push_back(e);
    endtask

    task automatic step_hand(input logic req, input logic [7:0] init_v, input logic [7:0] h_rn,
                             input logic [7:0] h_setn, input logic h_busy, input logic h_ack);
        exp_t e;
        @(negedge CLK);
        REQ  = req;
        RN   = 1'b1;
        INIT = init_v;
        model_edge(req, 1'b1, init_v);
        e.d0.rn   = h_rn;
        e.d0.setn = h_setn;
        e.d0.busy = h_busy;
        e.d0.ack  = h_ack;
        e.d1 = model_out(1);
        e.d2 = model_out(2);
        sb.push_back(e);
    endtask

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got rn=%h setn=%h busy=%b ack=%b, expected rn=%h setn=%h busy=%b ack=%b",
                     name, act.rn, act.setn, act.busy, act.ack, exp.rn, exp.setn, exp.busy, exp.ack);
        end
        compared++;
        if (((~act.rn & ~act.setn) !== 8'h00) || (act.rn !== 8'hFF && act.setn !== 8'hFF)) begin
            mismatched++;
            $display("FAIL %s_overlap: got rn=%h setn=%h, required no concurrent clear and set",
                     name, act.rn, act.setn);
        end
    endtask

    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.rn = rn_o0; a.setn = setn_o0; a.busy = busy0; a.ack = ack0;
                cmp("p2g1", a, e.d0);
                a.rn = rn_o1; a.setn = setn_o1; a.busy = busy1; a.ack = ack1;
                cmp("p1g1", a, e.d1);
                a.rn = rn_o2; a.setn = setn_o2; a.busy = busy2; a.ack = ack2;
                cmp("p4g3", a, e.d2);
            end
        end
    end

    initial begin
        logic [7:0] h_rn   [8] = '{8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        logic [7:0] h_setn [8] = '{8'hFF, 8'hFF, 8'hFF, 8'h5A, 8'h5A, 8'hFF, 8'hFF, 8'hFF};
        logic       h_busy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       h_ack  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        CLK  = 1'b0;
        RN   = 1'b0;
        REQ  = 1'b0;
        INIT = 8'h00;
        for (int k = 0; k < 3; k++) begin
            t[k]  = -1;
            iq[k] = 8'h00;
        end

        // Reset with REQ high: must not be accepted.
        step(1'b1, 1'b0, 8'h3C);
        step(1'b1, 1'b0, 8'h3C);

        // Default-parameter load of 0xA5 against hand-derived waveforms.
        for (int k = 0; k < 8; k++)
            step_hand((k == 0), (k == 0) ? 8'hA5 : 8'h00, h_rn[k], h_setn[k], h_busy[k], h_ack[k]);
        repeat (10) step(1'b0, 1'b1, 8'h00);

        // All-zeros and all-ones loads; INIT wiggles after acceptance.
        step(1'b1, 1'b1, 8'h00);
        repeat (17) step(1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b1, 8'hFF);
        repeat (17) step(1'b0, 1'b1, 8'($urandom));

        // REQ held high, INIT toggling every cycle.
        for (int k = 0; k < 48; k++)
            step(1'b1, 1'b1, (k % 2 == 1) ? 8'h96 : 8'h69);
        repeat (17) step(1'b0, 1'b1, 8'h00);

        // Reset while in SET, with REQ asserted during reset.
        step(1'b1, 1'b1, 8'hC3);
        repeat (3) step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77);
        repeat (12) step(1'b0, 1'b1, 8'h00);

        // Random soak.
        for (int k = 0; k < 10000; k++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 63) != 0), 8'($urandom));

        @(posedge CLK);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
